// File: rtl/iir_coeff_loader_if.sv
// Config channel between the CSR fabric and the IIR coefficient loader.
// A single valid/ready transfer carries either a coefficient write
// (cfg_commit = 0, cfg_addr/cfg_data used) or a commit request
// (cfg_commit = 1, cfg_addr/cfg_data ignored).
//   master : CSR side, drives cfg_valid/cfg_commit/cfg_addr/cfg_data
//   slave  : loader side, drives cfg_ready
interface iir_coeff_loader_if #(
    parameter int COEFF_WIDTH = 20
);
    logic                          cfg_valid;
    logic                          cfg_ready;
    logic                          cfg_commit;
    logic [2:0]                    cfg_addr;
    logic signed [COEFF_WIDTH-1:0] cfg_data;

    modport master (
        output cfg_valid,
        output cfg_commit,
        output cfg_addr,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_commit,
        input  cfg_addr,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/iir_coeff_loader.sv
// Coefficient loader for the IIR notch filter.
// Holds five shadow coefficients written over the config channel and, on a
// commit request, pulses the filter's numerator and denominator write strobes
// in separate cycles, each placed into a gap of the sample stream (or forced
// after TIMEOUT cycles without a gap).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg                 config channel (slave side)
//   sample_valid_i      filter input valid, watched for stream gaps
//   num_coeff_out_o     B0..B2 shadow values
//   den_coeff_out_o     A1..A2 shadow values
//   num_coeff_wr_en_o   numerator write strobe (combinational)
//   den_coeff_wr_en_o   denominator write strobe (combinational)
//   commit_done_o       one-cycle pulse at the end of a commit
//   forced_o            sticky: a strobe was forced by timeout
//   addr_err_o          sticky: a write hit an illegal address
//   err_clr_i           clears forced_o and addr_err_o
//
// state      | meaning
// S_IDLE     | accepting writes and commit requests
// S_COMMIT_N | waiting for a gap to strobe the numerator
// S_COMMIT_D | waiting for a gap to strobe the denominator
// S_DONE     | commit_done pulse, back to idle next cycle
module iir_coeff_loader #(
    parameter int                          COEFF_WIDTH = 20,
    parameter int                          TIMEOUT     = 64,
    parameter logic signed [COEFF_WIDTH-1:0] RST_B0    = 20'sh37061,
    parameter logic signed [COEFF_WIDTH-1:0] RST_B1    = 20'sh5907c,
    parameter logic signed [COEFF_WIDTH-1:0] RST_B2    = 20'sh37061,
    parameter logic signed [COEFF_WIDTH-1:0] RST_A1    = 20'sh5907c,
    parameter logic signed [COEFF_WIDTH-1:0] RST_A2    = 20'sh2e0c3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    iir_coeff_loader_if.slave             cfg,
    input  logic                          sample_valid_i,
    output logic signed [COEFF_WIDTH-1:0] num_coeff_out_o [0:2],
    output logic signed [COEFF_WIDTH-1:0] den_coeff_out_o [0:1],
    output logic                          num_coeff_wr_en_o,
    output logic                          den_coeff_wr_en_o,
    output logic                          commit_done_o,
    output logic                          forced_o,
    output logic                          addr_err_o,
    input  logic                          err_clr_i
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT_N,
        S_COMMIT_D,
        S_DONE
    } state_e;

    state_e                          state_q, state_d;
    logic signed [COEFF_WIDTH-1:0]   num_q [0:2];
    logic signed [COEFF_WIDTH-1:0]   num_d [0:2];
    logic signed [COEFF_WIDTH-1:0]   den_q [0:1];
    logic signed [COEFF_WIDTH-1:0]   den_d [0:1];
    logic                            dirty_num_q, dirty_num_d;
    logic                            dirty_den_q, dirty_den_d;
    logic [CNT_W-1:0]                wait_q, wait_d;
    logic                            forced_q, forced_d;
    logic                            addr_err_q, addr_err_d;
    logic                            gap_fire;
    logic                            num_we, den_we;

    // A strobe goes out in a stream gap, or unconditionally in the
    // TIMEOUT-th cycle spent waiting.
    assign gap_fire = !sample_valid_i || (wait_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            num_q[0]    <= RST_B0;
            num_q[1]    <= RST_B1;
            num_q[2]    <= RST_B2;
            den_q[0]    <= RST_A1;
            den_q[1]    <= RST_A2;
            dirty_num_q <= 1'b0;
            dirty_den_q <= 1'b0;
            wait_q      <= '0;
            forced_q    <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            den_q       <= den_d;
            dirty_num_q <= dirty_num_d;
            dirty_den_q <= dirty_den_d;
            wait_q      <= wait_d;
            forced_q    <= forced_d;
            addr_err_q  <= addr_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        den_d       = den_q;
        dirty_num_d = dirty_num_q;
        dirty_den_d = dirty_den_q;
        wait_d      = wait_q;
        forced_d    = forced_q;
        addr_err_d  = addr_err_q;
        num_we      = 1'b0;
        den_we      = 1'b0;

        // Clear first so a set event later in this block wins.
        if (err_clr_i) begin
            forced_d   = 1'b0;
            addr_err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg.cfg_valid) begin
                    if (cfg.cfg_commit) begin
                        wait_d = '0;
                        if (dirty_num_q)      state_d = S_COMMIT_N;
                        else if (dirty_den_q) state_d = S_COMMIT_D;
                        else                  state_d = S_DONE;
                    end else begin
                        case (cfg.cfg_addr)
                            3'd0: begin num_d[0] = cfg.cfg_data; dirty_num_d = 1'b1; end
                            3'd1: begin num_d[1] = cfg.cfg_data; dirty_num_d = 1'b1; end
                            3'd2: begin num_d[2] = cfg.cfg_data; dirty_num_d = 1'b1; end
                            3'd3: begin den_d[0] = cfg.cfg_data; dirty_den_d = 1'b1; end
                            3'd4: begin den_d[1] = cfg.cfg_data; dirty_den_d = 1'b1; end
                            default: addr_err_d = 1'b1;
                        endcase
                    end
                end
            end
            S_COMMIT_N: begin
                if (gap_fire) begin
                    num_we      = 1'b1;
                    dirty_num_d = 1'b0;
                    wait_d      = '0;
                    state_d     = dirty_den_q ? S_COMMIT_D : S_DONE;
                    if (sample_valid_i) forced_d = 1'b1;
                end else if (wait_q != CNT_MAX) begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_COMMIT_D: begin
                if (gap_fire) begin
                    den_we      = 1'b1;
                    dirty_den_d = 1'b0;
                    wait_d      = '0;
                    state_d     = S_DONE;
                    if (sample_valid_i) forced_d = 1'b1;
                end else if (wait_q != CNT_MAX) begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cfg.cfg_ready       = (state_q == S_IDLE);
    assign commit_done_o       = (state_q == S_DONE);
    assign num_coeff_wr_en_o   = num_we;
    assign den_coeff_wr_en_o   = den_we;
    assign forced_o            = forced_q;
    assign addr_err_o          = addr_err_q;
    assign num_coeff_out_o     = num_q;
    assign den_coeff_out_o     = den_q;
endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed testbench for iir_coeff_loader with a scoreboard of expected
// strobe / commit_done events (kind and cycle) pushed as commits are issued.
module tb_iir_coeff_loader;
    localparam int CW = 20;
    localparam logic signed [CW-1:0] RB0 = 20'sh37061;
    localparam logic signed [CW-1:0] RB1 = 20'sh5907c;
    localparam logic signed [CW-1:0] RB2 = 20'sh37061;
    localparam logic signed [CW-1:0] RA1 = 20'sh5907c;
    localparam logic signed [CW-1:0] RA2 = 20'sh2e0c3;

    localparam int EV_NUM  = 0;
    localparam int EV_DEN  = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk;
    logic rst_n;
    logic sample_valid;
    logic err_clr;
    logic signed [CW-1:0] num_out [0:2];
    logic signed [CW-1:0] den_out [0:1];
    logic num_we, den_we, commit_done, forced, addr_err;

    iir_coeff_loader_if #(.COEFF_WIDTH(CW)) cfg_if ();

    iir_coeff_loader #(.COEFF_WIDTH(CW), .TIMEOUT(64)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg               (cfg_if),
        .sample_valid_i    (sample_valid),
        .num_coeff_out_o   (num_out),
        .den_coeff_out_o   (den_out),
        .num_coeff_wr_en_o (num_we),
        .den_coeff_wr_en_o (den_we),
        .commit_done_o     (commit_done),
        .forced_o          (forced),
        .addr_err_o        (addr_err),
        .err_clr_i         (err_clr)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    ev_t sb[$];
    logic signed [CW-1:0] exp_num [0:2];
    logic signed [CW-1:0] exp_den [0:1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_w(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_shadows(input string tag);
        for (int i = 0; i < 3; i++) chk_w($sformatf("%s_num%0d", tag, i), num_out[i], exp_num[i]);
        for (int i = 0; i < 2; i++) chk_w($sformatf("%s_den%0d", tag, i), den_out[i], exp_den[i]);
    endtask

    task automatic model_reset();
        exp_num[0] = RB0; exp_num[1] = RB1; exp_num[2] = RB2;
        exp_den[0] = RA1; exp_den[1] = RA2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Event monitor: every strobe / done pulse must match the scoreboard head.
    task automatic check_ev(input int kind);
        ev_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_unexpected observed kind=%0d at cyc=%0d expected no event", kind, cyc);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (kind === e.kind && cyc === e.cyc) else begin
                errors++;
                $error("FAIL sb_event observed kind=%0d cyc=%0d expected kind=%0d cyc=%0d",
                       kind, cyc, e.kind, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (!(num_we && den_we)) else begin
                errors++;
                $error("FAIL strobe_exclusive observed num=%b den=%b expected not both", num_we, den_we);
            end
            if (num_we)      check_ev(EV_NUM);
            if (den_we)      check_ev(EV_DEN);
            if (commit_done) check_ev(EV_DONE);
        end
    end

    task automatic cfg_write(input logic [2:0] a, input logic [CW-1:0] d);
        chk_bit("write_ready", cfg_if.cfg_ready, 1'b1);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_commit = 1'b0;
        cfg_if.cfg_addr   = a;
        cfg_if.cfg_data   = d;
        if (int'(a) < 3)      exp_num[int'(a)] = d;
        else if (int'(a) < 5) exp_den[int'(a) - 3] = d;
        tick();
        cfg_if.cfg_valid = 1'b0;
        chk_shadows("after_write");
    endtask

    // Offsets relative to the first cycle after acceptance; -1 = no event.
    task automatic cfg_commit_req(input int num_off, input int den_off, input int done_off);
        int n;
        ev_t e;
        n = cyc + 1;
        if (num_off >= 0)  begin e.kind = EV_NUM;  e.cyc = n + num_off;  sb.push_back(e); end
        if (den_off >= 0)  begin e.kind = EV_DEN;  e.cyc = n + den_off;  sb.push_back(e); end
        if (done_off >= 0) begin e.kind = EV_DONE; e.cyc = n + done_off; sb.push_back(e); end
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_commit = 1'b1;
        cfg_if.cfg_addr   = 3'd7;
        tick();
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_commit = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!cfg_if.cfg_ready && k < budget) begin
            tick();
            k++;
        end
        chk_bit("wait_idle_ready", cfg_if.cfg_ready, 1'b1);
    endtask

    initial begin
        rst_n             = 1'b0;
        sample_valid      = 1'b0;
        err_clr           = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_commit = 1'b0;
        cfg_if.cfg_addr   = 3'd0;
        cfg_if.cfg_data   = '0;
        model_reset();

        // 1. reset defaults
        repeat (3) tick();
        chk_shadows("reset");
        chk_bit("reset_num_we", num_we, 1'b0);
        chk_bit("reset_den_we", den_we, 1'b0);
        chk_bit("reset_done", commit_done, 1'b0);
        chk_bit("reset_forced", forced, 1'b0);
        chk_bit("reset_addr_err", addr_err, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_bit("reset_ready", cfg_if.cfg_ready, 1'b1);

        // 2. full commit on an idle stream
        cfg_write(3'd1, 20'shc8f9f);
        cfg_write(3'd3, 20'shc8f9f);
        cfg_commit_req(0, 1, 2);
        chk_bit("t2_ready_busy", cfg_if.cfg_ready, 1'b0);
        repeat (2) tick();
        chk_bit("t2_ready_done_cycle", cfg_if.cfg_ready, 1'b0);
        tick();
        chk_bit("t2_ready_back", cfg_if.cfg_ready, 1'b1);
        chk_w("t2_b1", num_out[1], 20'shc8f9f);
        chk_w("t2_a1", den_out[0], 20'shc8f9f);
        chk_bit("t2_forced", forced, 1'b0);

        // 3. gap alignment: den strobe in first idle sample slot
        cfg_write(3'd4, 20'sh12345);
        sample_valid = 1'b1;
        cfg_commit_req(-1, 10, 11);
        repeat (10) tick();
        sample_valid = 1'b0;
        wait_idle(10);
        chk_bit("t3_forced", forced, 1'b0);
        chk_w("t3_a2", den_out[1], 20'sh12345);

        // 4. timeout on a saturated stream
        cfg_write(3'd0, 20'sh01000);
        cfg_write(3'd4, 20'sh00800);
        sample_valid = 1'b1;
        cfg_commit_req(63, 127, 128);
        repeat (63) tick();
        chk_bit("t4_forced_before", forced, 1'b0);
        tick();
        chk_bit("t4_forced_after_num", forced, 1'b1);
        wait_idle(200);
        sample_valid = 1'b0;
        chk_bit("t4_forced_sticky", forced, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk_bit("t4_forced_cleared", forced, 1'b0);

        // 5. illegal address, set-beats-clear, empty commit
        cfg_write(3'd6, 20'sh7ffff);
        chk_bit("t5_addr_err", addr_err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk_bit("t5_addr_err_clr", addr_err, 1'b0);
        err_clr = 1'b1;
        cfg_write(3'd5, 20'sh00001);
        err_clr = 1'b0;
        chk_bit("t5_set_wins", addr_err, 1'b1);
        cfg_commit_req(-1, -1, 0);
        chk_bit("t5_done_pulse", commit_done, 1'b1);
        tick();
        chk_bit("t5_ready_back", cfg_if.cfg_ready, 1'b1);

        // 6. reset while waiting in the denominator state
        cfg_write(3'd3, 20'sh22222);
        sample_valid = 1'b1;
        cfg_commit_req(-1, -1, -1);
        repeat (2) tick();
        chk_bit("t6_busy", cfg_if.cfg_ready, 1'b0);
        rst_n = 1'b0;
        sample_valid = 1'b0;
        model_reset();
        #1;
        chk_bit("t6_num_we", num_we, 1'b0);
        chk_bit("t6_den_we", den_we, 1'b0);
        chk_bit("t6_idle", cfg_if.cfg_ready, 1'b1);
        chk_bit("t6_addr_err", addr_err, 1'b0);
        chk_shadows("t6_shadows");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk_bit("t6_no_done", commit_done, 1'b0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drained observed pending=%0d expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/iir_coeff_loader.md
# iir_coeff_loader

Configuration-side initiator for the IIR notch filter's coefficient write port. Accepts single coefficient writes over a valid/ready config channel into five shadow registers, then on a commit request drives the filter's `num_coeff_wr_en` / `den_coeff_wr_en` strobes in separate cycles, timed into gaps of the sample stream. It sits between the register/CSR fabric and each IIR instance in the DFE chain.

## Interface
- COEFF_WIDTH, 20: coefficient width, signed Q2.18.
- TIMEOUT, 64: maximum cycles to wait for a sample gap before forcing a strobe; must be at least 1.
- RST_B0 / RST_B1 / RST_B2, 20'sh37061 / 20'sh5907c / 20'sh37061: reset values of the numerator shadow registers.
- RST_A1 / RST_A2, 20'sh5907c / 20'sh2e0c3: reset values of the denominator shadow registers.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  config transfer valid.
- cfg_ready  out  1  loader can accept a transfer.
- cfg_commit  in  1  qualifies a transfer as a commit request; cfg_addr and cfg_data are ignored.
- cfg_addr  in  3  target register: 0=B0, 1=B1, 2=B2, 3=A1, 4=A2, 5–7 illegal.
- cfg_data  in  COEFF_WIDTH  signed coefficient value.
- sample_valid  in  1  filter input valid (the filter's `valid_in`), observed for gap detection.
- num_coeff_out[0:2]  out  COEFF_WIDTH each  B0..B2 shadow values, driven continuously.
- den_coeff_out[0:1]  out  COEFF_WIDTH each  A1..A2 shadow values, driven continuously.
- num_coeff_wr_en  out  1  numerator write strobe.
- den_coeff_wr_en  out  1  denominator write strobe.
- commit_done  out  1  one-cycle pulse when a commit completes.
- forced  out  1  sticky: a strobe was forced by timeout.
- addr_err  out  1  sticky: a write targeted an illegal address.
- err_clr  in  1  synchronous clear of `forced` and `addr_err`.

## Operation
- **Reset values:** shadows take their RST_* values; dirty bits = 00; state = IDLE; all strobes, `commit_done`, `forced` and `addr_err` = 0.
- **Acceptance:** a transfer is accepted when `cfg_valid && cfg_ready`. `cfg_ready` = (state == IDLE).
- **Write (`cfg_commit` = 0):**
  - Address 0–2 updates the shadow and sets dirty_num.
  - Address 3–4 updates the shadow and sets dirty_den.
  - Address 5–7 changes no shadow and sets `addr_err`.
  - The shadow update is visible on `*_coeff_out` the next cycle.
- **Commit (`cfg_commit` = 1):** the next state is chosen from the dirty bits.
  - dirty_num set → COMMIT_NUM.
  - Otherwise dirty_den set → COMMIT_DEN.
  - Otherwise (no dirty bits) → DONE, with no strobe issued.
- **FSM states:** IDLE, COMMIT_NUM, COMMIT_DEN, DONE.
- **COMMIT_NUM:**
  - `num_coeff_wr_en` = !sample_valid || (wait_cnt == TIMEOUT−1). This strobe is combinational (Mealy).
  - When the strobe fires: clear dirty_num, reset wait_cnt, then go to COMMIT_DEN if dirty_den is set, else DONE.
  - If the strobe fired while sample_valid = 1, set `forced`.
- **COMMIT_DEN:** same rules as COMMIT_NUM, using `den_coeff_wr_en` and dirty_den.
- **Strobe exclusivity:** `num_coeff_wr_en` and `den_coeff_wr_en` are never high in the same cycle. The filter gives num priority, so a simultaneous strobe would drop the den write.
- **DONE:** `commit_done` = 1 for one cycle, then IDLE.
- **wait_cnt:**
  - Width is $clog2(TIMEOUT+1).
  - Increments each cycle in COMMIT_* while no strobe fires.
  - Saturates; never wraps.
  - Clears on state entry.
- **Shadow stability:** shadows cannot change during a commit because `cfg_ready` = 0. The written value is therefore exactly the shadow value at commit acceptance.
- **Sticky error flags:** `err_clr` clears `forced` and `addr_err`. If a set event occurs in the same cycle as `err_clr`, set wins.
- **Reset mid-commit:** all state returns to the reset values, including the shadows, so pending writes are lost. The filter also resets to its own defaults, so the two remain consistent.

## Timing
- Write accepted at edge N → `*_coeff_out` updated after edge N.
- Commit accepted at edge N:
  - State = COMMIT_NUM during cycle N+1.
  - The strobe fires combinationally in the first cycle with sample_valid = 0.
  - With a continuously idle stream, num strobe in N+1, den strobe in N+2, `commit_done` in N+3, `cfg_ready` back in N+4.
- Worst case per group: the strobe fires in the TIMEOUT-th cycle of the state.
- `cfg_ready`, `commit_done`, `forced` and `addr_err` are registered outputs. The two strobes are combinational from state, sample_valid and wait_cnt.

## Test plan
1. **Reset defaults:** assert rst_n low → `num_coeff_out` = {37061, 5907c, 37061}, `den_coeff_out` = {5907c, 2e0c3}, all strobes 0, `cfg_ready` = 1 after release.
2. **Full commit, idle stream:** write B1 = 20'shc8f9f and A1 = 20'shc8f9f, then commit with sample_valid = 0 → num strobe at N+1, den strobe at N+2 (never together), `commit_done` at N+3, `num_coeff_out[1]` = c8f9f.
3. **Gap alignment:** write A2 only, commit, hold sample_valid = 1 for 10 cycles then 0 → no num strobe; den strobe in the first cycle with sample_valid = 0; `forced` stays 0.
4. **Timeout:** TIMEOUT = 64, sample_valid held at 1 → num strobe in the 64th cycle of COMMIT_NUM and `forced` = 1; den is forced 64 cycles later; `err_clr` then clears `forced`.
5. **Illegal address and empty commit:** write to address 6 → `addr_err` = 1, shadows unchanged. Then commit with no dirty bits → `commit_done` at N+1 with no strobes.
6. **Reset mid-commit:** assert reset while in COMMIT_DEN → strobes drop immediately, shadows return to the RST_* values, state = IDLE.
